lfsr_param: RTL
===============

Name: lfsr_param

Overview:
Parametrised LFSR generator, the successor to the fixed 16-bit LFSR. Adds run-time selection between Fibonacci and Galois form, synchronous seed load with zero-seed protection, a step counter, and a one-cycle wrap pulse when the sequence returns to its start value. Used as a pseudo-random source and as a BIST pattern generator in sequential-design blocks.

Parameters:
WIDTH, 16, register width in bits; legal range 3..32.
TAPS, 16'hB400, Fibonacci tap mask; bit k set means state[k] feeds the XOR. Bit WIDTH-1 must be set. The default gives x^16+x^14+x^13+x^11+1.
SEED, 16'h0001, value loaded at reset and substituted for an all-zero load; must be non-zero.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  advance one step per clock while high
load  input  1  synchronous seed load; has priority over enable
seed_in  input  WIDTH  seed value captured when load=1
mode  input  1  0 = Fibonacci, 1 = Galois; sampled every step
lfsr  output  WIDTH  current state (registered)
bit_out  output  1  lfsr[WIDTH-1]
count  output  WIDTH  number of enabled steps since the last reset, load or wrap (registered)
wrap  output  1  one-cycle pulse: the state has just returned to start

Behaviour:
- Reset (reset_n=0, asynchronous):
  - lfsr=SEED, start=SEED, count=0, wrap=0.
  - Takes effect immediately; state is held until release.
  - Reset during operation discards any pending step.
- Internal register start holds the reference value for wrap detection.
  - start is updated only on reset or load.
- Galois mask: G[j]=TAPS[WIDTH-1-j], fixed at elaboration. G[0] is always 1. The default G is 16'h002D, the reciprocal polynomial, so the period is the same as Fibonacci.
- Fibonacci step: fb = XOR-reduce(lfsr & TAPS); next = {lfsr[WIDTH-2:0], fb}.
- Galois step: next = {lfsr[WIDTH-2:0], 1'b0} XOR (lfsr[WIDTH-1] ? G : 0).
- Priority on each rising edge: load, then enable, then hold.
  - load=1: s = (seed_in==0) ? SEED : seed_in. Then lfsr=s, start=s, count=0, wrap=0. Any enable in the same cycle is ignored.
  - enable=1, load=0: lfsr=next (mode selects the step function).
    - If next==start: wrap=1 for one cycle and count=0.
    - Otherwise: wrap=0 and count=count+1, modulo 2^WIDTH.
  - enable=0, load=0: lfsr and count hold; wrap=0.
- Latency: the new state appears on lfsr one clock after the enabling edge. wrap is registered and coincides with lfsr==start.
- The all-zero state is unreachable. Reset and load never produce it, and a non-zero XOR state never steps to zero.
- Changing mode mid-run is legal: the next step uses the new function. start is unchanged, so wrap may never fire; this is acceptable and not flagged.
- For a primitive TAPS polynomial, wrap fires every 2^WIDTH-1 enabled steps.
  - count then peaks at 2^WIDTH-2 before clearing.
- bit_out is combinational from the lfsr register (no added latency).

Test Plan:
- Reset/hold, defaults: reset_n=0 then release with enable=0 for 3 clocks -> lfsr=0x0001, count=0, wrap=0 throughout.
- Step from reset, defaults: enable=1 for 4 clocks from SEED 0x0001, mode=0 and again mode=1 -> lfsr sequence 0x0002, 0x0004, 0x0008, 0x0010 in both modes; count=1..4.
- Mode divergence: load seed_in=0x8000, then one enabled step -> mode=0 gives lfsr=0x0001; mode=1 gives lfsr=0x002D.
- Zero-seed protection, plus load over enable: load=1, enable=1, seed_in=0 -> lfsr=0x0001, count=0; no step taken that cycle.
- Period and wrap, WIDTH=4, TAPS=4'b1100, SEED=1: run 40 enabled steps in each mode -> wrap pulses exactly at steps 15 and 30; count peaks at 14; all 15 non-zero states are visited once per period.
- Async reset mid-run: assert reset_n=0 between clock edges while enable=1 -> lfsr=SEED, count=0, wrap=0 immediately, without waiting for an edge; stepping resumes from SEED after release.

Source files
------------

// File: rtl/lfsr_param.sv
// Parametrised LFSR with run-time Fibonacci/Galois selection, zero-safe seed
// load, a step counter and a one-cycle wrap pulse on return to the start value.
module lfsr_param #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] lfsr,
  output logic             bit_out,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // Galois mask is the bit-reversed Fibonacci tap set (reciprocal polynomial).
  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < WIDTH; j++) r[j] = v[WIDTH-1-j];
    return r;
  endfunction

  localparam logic [WIDTH-1:0] GMASK = reverse(TAPS);

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] nxt_fib;
  logic [WIDTH-1:0] nxt_gal;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] seed_ld;

  always_comb begin
    nxt_fib = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    nxt_gal = {lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? GMASK : '0);
    nxt     = mode ? nxt_gal : nxt_fib;
    // An all-zero seed would lock the register; fall back to SEED.
    seed_ld = (seed_in == '0) ? SEED : seed_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr  <= SEED;
      start <= SEED;
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      lfsr  <= seed_ld;
      start <= seed_ld;
      count <= '0;
      wrap  <= 1'b0;
    end else if (enable) begin
      lfsr <= nxt;
      if (nxt == start) begin
        wrap  <= 1'b1;
        count <= '0;
      end else begin
        wrap  <= 1'b0;
        count <= count + WIDTH'(1);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign bit_out = lfsr[WIDTH-1];

endmodule
